// File: rtl/alu_bus_master_pkg.sv
// Shared ALU op codes, NZCV bit positions and the bus-master sequencer states.
package alu_bus_master_pkg;

  localparam logic [4:0] ALU_NOP   = 5'd0;
  localparam logic [4:0] ALU_SUM_2 = 5'd1;
  localparam logic [4:0] ALU_SUB_2 = 5'd2;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_DRIVE,
    ST_SETTLE,
    ST_READ,
    ST_DONE
  } state_e;

  function automatic logic op_supported(input logic [4:0] op);
    return (op == ALU_SUM_2) || (op == ALU_SUB_2);
  endfunction

endpackage

// File: rtl/alu_bus_driver.sv
// Tri-state driver for the 16-bit operand lane of the shared bus; releases to Z when disabled.
module alu_bus_driver (
  input  logic        drive_en_i,
  input  logic [15:0] drive_dat_i,
  inout  wire  [15:0] bus_io
);

  assign bus_io = drive_en_i ? drive_dat_i : 16'bz;

endmodule

// File: rtl/alu_bus_master.sv
// Sequences one 2-operand ALU op over the shared bus and holds the captured result/flags.
// Start->done is 4+SETTLE_CYCLES cycles with immediate grant; starts while busy are dropped.
module alu_bus_master #(
  parameter int SETTLE_CYCLES = 0,
  parameter int GRANT_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [4:0]  i_op,
  input  logic [7:0]  i_opA,
  input  logic [7:0]  i_opB,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [7:0]  o_result,
  output logic [3:0]  o_nzcv,
  output logic        o_busReq,
  input  logic        i_busGrant,
  output logic [4:0]  o_aluOp,
  output logic        o_aluReadData,
  output logic        o_aluReadFlags,
  input  logic [3:0]  i_aluNzcv,
  inout  wire  [23:0] io_bus
);
  import alu_bus_master_pkg::*;

  // One shared 8-bit counter serves both the grant wait and the settle window.
  localparam logic [7:0] GRANT_LAST  = 8'(GRANT_TIMEOUT - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] op_q, op_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       err_q, err_d;
  logic [7:0] result_q, result_d;
  logic [3:0] nzcv_q, nzcv_d;
  logic       drive_en;
  logic       unused_bus;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    err_d    = err_q;
    result_d = result_q;
    nzcv_d   = nzcv_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          op_d    = i_op;
          a_d     = i_opA;
          b_d     = i_opB;
          cnt_d   = '0;
          err_d   = !op_supported(i_op);
          state_d = op_supported(i_op) ? ST_REQ : ST_DONE;
        end
      end
      ST_REQ: begin
        if (i_busGrant) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end else if ((GRANT_TIMEOUT != 0) && (cnt_q == GRANT_LAST)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DRIVE: begin
        cnt_d   = '0;
        state_d = (SETTLE_CYCLES == 0) ? ST_READ : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = ST_READ;
        else                      cnt_d   = cnt_q + 8'd1;
      end
      ST_READ: begin
        // Flags are taken verbatim from the ALU; no local recomputation.
        result_d = io_bus[7:0];
        nzcv_d   = i_aluNzcv;
        state_d  = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= ALU_NOP;
      a_q      <= '0;
      b_q      <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      nzcv_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      err_q    <= err_d;
      result_q <= result_d;
      nzcv_q   <= nzcv_d;
    end
  end

  assign drive_en       = (state_q == ST_DRIVE) || (state_q == ST_SETTLE);
  assign o_busy         = (state_q != ST_IDLE);
  assign o_done         = (state_q == ST_DONE);
  assign o_error        = err_q;
  assign o_result       = result_q;
  assign o_nzcv         = nzcv_q;
  assign o_busReq       = state_q inside {ST_REQ, ST_DRIVE, ST_SETTLE, ST_READ};
  assign o_aluOp        = (state_q == ST_DRIVE) ? op_q : ALU_NOP;
  assign o_aluReadData  = (state_q == ST_READ);
  assign o_aluReadFlags = (state_q == ST_READ);

  alu_bus_driver u_drv (
    .drive_en_i  (drive_en),
    .drive_dat_i ({a_q, b_q}),
    .bus_io      (io_bus[15:0])
  );

  assign io_bus[23:16] = 8'bz;
  assign unused_bus    = ^io_bus[23:8];

endmodule

// File: tb/tb_alu_bus_master.sv
// Bench: two masters (SETTLE 0 / timeout 4, and SETTLE 3) each with an ALU2 and arbiter model.
module tb_alu_bus_master;
  import alu_bus_master_pkg::*;

  typedef struct {
    int         inst;
    int         t0;
    int         lat;
    logic       err;
    logic [7:0] res;
    logic [3:0] nzcv;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   hit;
  exp_t sb[$];

  logic       rst;
  logic [4:0] op;
  logic [7:0] opa, opb;

  logic       start_a, allow_a, grant_a;
  logic       busy_a, done_a, err_a, req_a, rdd_a, rdf_a;
  logic [7:0] res_a, alu_res_a;
  logic [3:0] nzcv_a, alu_fl_a;
  logic [4:0] aluop_a;
  wire  [23:0] bus_a;
  wire  [3:0]  alunz_a;
  logic       v_seen_a, req_seen_a;

  logic       start_b, allow_b, grant_b;
  logic       busy_b, done_b, err_b, req_b, rdd_b, rdf_b;
  logic [7:0] res_b, alu_res_b;
  logic [3:0] nzcv_b, alu_fl_b;
  logic [4:0] aluop_b;
  wire  [23:0] bus_b;
  wire  [3:0]  alunz_b;
  logic       v_seen_b;

  alu_bus_master #(.SETTLE_CYCLES(0), .GRANT_TIMEOUT(4)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_start(start_a), .i_op(op), .i_opA(opa), .i_opB(opb),
    .o_busy(busy_a), .o_done(done_a), .o_error(err_a), .o_result(res_a), .o_nzcv(nzcv_a),
    .o_busReq(req_a), .i_busGrant(grant_a), .o_aluOp(aluop_a), .o_aluReadData(rdd_a),
    .o_aluReadFlags(rdf_a), .i_aluNzcv(alunz_a), .io_bus(bus_a)
  );

  alu_bus_master #(.SETTLE_CYCLES(3), .GRANT_TIMEOUT(255)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_start(start_b), .i_op(op), .i_opA(opa), .i_opB(opb),
    .o_busy(busy_b), .o_done(done_b), .o_error(err_b), .o_result(res_b), .o_nzcv(nzcv_b),
    .o_busReq(req_b), .i_busGrant(grant_b), .o_aluOp(aluop_b), .o_aluReadData(rdd_b),
    .o_aluReadFlags(rdf_b), .i_aluNzcv(alunz_b), .io_bus(bus_b)
  );

  // ALU2 reference: executes on the negedge while an op code is presented.
  function automatic logic [11:0] alu_calc(input logic [4:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic       c, v;
    if (o == ALU_SUB_2) begin
      s = {1'b0, a} - {1'b0, b};
      c = (a < b);
      v = (a[7] != b[7]) && (s[7] != a[7]);
    end else begin
      s = {1'b0, a} + {1'b0, b};
      c = s[8];
      v = (a[7] == b[7]) && (s[7] != a[7]);
    end
    return {s[7], s[7:0] == 8'h00, c, v, s[7:0]};
  endfunction

  pullup (bus_a);
  pullup (bus_b);
  assign grant_a      = req_a & allow_a;
  assign grant_b      = req_b & allow_b;
  assign bus_a[7:0]   = rdd_a ? alu_res_a : 8'bz;
  assign bus_b[7:0]   = rdd_b ? alu_res_b : 8'bz;
  assign alunz_a      = rdf_a ? alu_fl_a : 4'bz;
  assign alunz_b      = rdf_b ? alu_fl_b : 4'bz;

  always @(negedge clk) if (aluop_a != ALU_NOP) {alu_fl_a, alu_res_a} <= alu_calc(aluop_a, bus_a[15:8], bus_a[7:0]);
  always @(negedge clk) if (aluop_b != ALU_NOP) {alu_fl_b, alu_res_b} <= alu_calc(aluop_b, bus_b[15:8], bus_b[7:0]);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bus_mon(input string sfx, input logic busy, input logic rdd, input logic rdf,
                         input logic [4:0] aop, input logic [23:0] bus, input logic [7:0] alures);
    if (!busy) chk({"idle_bus_z", sfx}, 32'(bus), 32'hFFFFFF);
    if (rdd) begin
      chk({"read_flags_en", sfx}, 32'(rdf), 32'd1);
      chk({"read_bus", sfx}, 32'(bus), {8'h00, 16'hFFFF, alures});
    end
    if (aop != ALU_NOP) chk({"drive_bus", sfx}, 32'(bus), {8'h00, 8'hFF, opa, opb});
  endtask

  task automatic check_done(input int inst, input logic err, input logic [7:0] res,
                            input logic [3:0] nzcv, input logic req, input logic v);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done: inst %0d pulsed o_done with nothing outstanding (cycle %0d)", inst, cyc);
    end else begin
      e = sb.pop_front();
      chk("done_inst", 32'(inst), 32'(e.inst));
      chk("latency", 32'(cyc - e.t0), 32'(e.lat));
      chk("error", 32'(err), 32'(e.err));
      chk("result", 32'(res), 32'(e.res));
      chk("nzcv", 32'(nzcv), 32'(e.nzcv));
      chk("busreq_in_done", 32'(req), 32'd0);
      if (!e.err) chk("v_from_alu", 32'(nzcv[NZCV_V]), 32'(v));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bus_mon("_a", busy_a, rdd_a, rdf_a, aluop_a, bus_a, alu_res_a);
      bus_mon("_b", busy_b, rdd_b, rdf_b, aluop_b, bus_b, alu_res_b);
      if (rdd_a) v_seen_a = alunz_a[NZCV_V];
      if (rdd_b) v_seen_b = alunz_b[NZCV_V];
      if (req_a) req_seen_a = 1'b1;
      if (done_a) check_done(0, err_a, res_a, nzcv_a, req_a, v_seen_a);
      if (done_b) check_done(1, err_b, res_b, nzcv_b, req_b, v_seen_b);
    end
  end

  task automatic issue(input int inst, input logic [4:0] o, input logic [7:0] a, input logic [7:0] b,
                       input bit expect_done, input int lat, input logic e,
                       input logic [7:0] r, input logic [3:0] f);
    @(negedge clk);
    op  = o;
    opa = a;
    opb = b;
    if (inst == 0) start_a = 1'b1;
    else           start_b = 1'b1;
    if (expect_done) sb.push_back('{inst, cyc, lat, e, r, f});
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: %0d completions pending, want 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_for(input bit is_read_a);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      hit = is_read_a ? rdd_a : (aluop_b != ALU_NOP);
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL phase_timeout: awaited %s phase never seen, want it within 20 cycles",
               is_read_a ? "READ" : "DRIVE");
    end
  endtask

  initial begin
    rst = 1'b1; op = ALU_NOP; opa = '0; opb = '0;
    start_a = 1'b0; start_b = 1'b0; allow_a = 1'b1; allow_b = 1'b1;
    v_seen_a = 1'b0; v_seen_b = 1'b0; req_seen_a = 1'b0;
    alu_res_a = '0; alu_res_b = '0; alu_fl_a = '0; alu_fl_b = '0;
    repeat (3) @(negedge clk);

    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_error", 32'(err_a), 32'd0);
    chk("rst_busreq", 32'(req_a), 32'd0);
    chk("rst_readdata", 32'(rdd_a), 32'd0);
    chk("rst_readflags", 32'(rdf_a), 32'd0);
    chk("rst_result", 32'(res_a), 32'h00);
    chk("rst_nzcv", 32'(nzcv_a), 32'h0);
    chk("rst_aluop", 32'(aluop_a), 32'(ALU_NOP));
    chk("rst_bus", 32'(bus_a), 32'hFFFFFF);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    issue(0, ALU_SUM_2, 8'h05, 8'h03, 1, 4, 1'b0, 8'h08, 4'b0000); wait_drain();
    issue(0, ALU_SUM_2, 8'hFF, 8'h01, 1, 4, 1'b0, 8'h00, 4'b0110); wait_drain();
    issue(0, ALU_SUB_2, 8'h03, 8'h05, 1, 4, 1'b0, 8'hFE, 4'b1010); wait_drain();

    req_seen_a = 1'b0;
    issue(0, ALU_NOP, 8'h12, 8'h34, 1, 1, 1'b1, 8'hFE, 4'b1010); wait_drain();
    chk("nop_no_busreq", 32'(req_seen_a), 32'd0);

    allow_a = 1'b0;
    issue(0, ALU_SUM_2, 8'h05, 8'h03, 1, 5, 1'b1, 8'hFE, 4'b1010); wait_drain();
    allow_a = 1'b1;

    // Second start lands in READ and must be dropped.
    issue(0, ALU_SUM_2, 8'h05, 8'h03, 1, 4, 1'b0, 8'h08, 4'b0000);
    wait_for(1'b1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_drain();
    repeat (6) @(negedge clk);

    issue(1, ALU_SUB_2, 8'h03, 8'h05, 1, 7, 1'b0, 8'hFE, 4'b1010); wait_drain();

    // Abort from SETTLE: no completion expected for this op.
    issue(1, ALU_SUB_2, 8'h03, 8'h05, 0, 0, 1'b0, 8'h00, 4'b0000);
    wait_for(1'b0);
    @(negedge clk);
    chk("settle_aluop_nop", 32'(aluop_b), 32'(ALU_NOP));
    chk("settle_bus_driven", 32'(bus_b), {8'h00, 8'hFF, opa, opb});
    rst = 1'b1;
    @(negedge clk);
    chk("abort_bus_z", 32'(bus_b), 32'hFFFFFF);
    chk("abort_busreq", 32'(req_b), 32'd0);
    chk("abort_busy", 32'(busy_b), 32'd0);
    chk("abort_done", 32'(done_b), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    issue(1, ALU_SUM_2, 8'hFF, 8'h01, 1, 7, 1'b0, 8'h00, 4'b0110); wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_bus_master.md
Name: alu_bus_master

Overview:
- Initiator-side sequencer for the 2-operand ALU on the shared 24-bit tri-state data bus.
- Accepts an operation request from the control unit and requests the bus.
- Drives operand A on bus[15:8] and operand B on bus[7:0], and issues the ALU op code.
- Releases the bus, enables ALU result/flag readout, and captures the result and NZCV flags into holding registers for the control unit.

Parameters:
- SETTLE_CYCLES, 0, extra cycles operands stay driven after the first ALU negedge (0..15).
- GRANT_TIMEOUT, 255, max cycles to wait for i_busGrant; 0 = wait forever.

Ports:
- i_clk  input  1  system clock; all state changes on posedge.
- i_reset  input  1  synchronous, active-high reset (sampled on posedge i_clk).
- i_start  input  1  request strobe; sampled only in IDLE.
- i_op  input  5  ALU op code (ALU_* encodings).
- i_opA  input  8  first operand (minuend/addend).
- i_opB  input  8  second operand (subtrahend/addend).
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle completion pulse.
- o_error  output  1  valid with o_done: unsupported op or grant timeout.
- o_result  output  8  captured ALU result, held until next completion.
- o_nzcv  output  4  captured flags {N,Z,C,V}, held until next completion.
- o_busReq  output  1  bus request to arbiter.
- i_busGrant  input  1  bus grant from arbiter.
- o_aluOp  output  5  op code to ALU; ALU_NOP except in DRIVE.
- o_aluReadData  output  1  ALU result-to-bus enable.
- o_aluReadFlags  output  1  ALU flag output enable.
- i_aluNzcv  input  4  ALU flag lines (Z when not enabled).
- io_bus  inout  24  shared data bus.

Behaviour:
- Reset: state=IDLE. o_busy, o_done, o_error, o_busReq, o_aluReadData and o_aluReadFlags are 0. o_result=0x00, o_nzcv=0000, o_aluOp=ALU_NOP. io_bus is all Z. Reset mid-operation aborts immediately with no o_done.
- io_bus[23:16] is always Z. io_bus[15:0] is driven only in DRIVE and SETTLE, otherwise Z.
- IDLE: on i_start, latch i_op/i_opA/i_opB.
  - Op not ALU_SUM_2 or ALU_SUB_2 -> DONE with error=1; no bus request issued.
  - Otherwise -> REQ.
  - i_start while busy is ignored; the request is not queued.
- REQ: o_busReq=1.
  - i_busGrant=1 -> DRIVE.
  - Counter reaches GRANT_TIMEOUT (counted from REQ entry) -> DONE with error=1; o_busReq drops.
- DRIVE (1 cycle): o_busReq held; bus[15:8]=A, bus[7:0]=B, o_aluOp=latched op. The ALU executes on the negedge inside this cycle.
  - SETTLE_CYCLES=0 -> READ; else -> SETTLE.
- SETTLE: operands stay driven; o_aluOp=ALU_NOP so the ALU does not re-execute. Lasts SETTLE_CYCLES cycles, then -> READ.
- READ (1 cycle): bus released (Z); o_aluReadData=1, o_aluReadFlags=1, o_busReq held. At the closing posedge, capture o_result<=io_bus[7:0] and o_nzcv<=i_aluNzcv verbatim, with no recomputation. -> DONE.
- DONE (1 cycle): o_done=1; o_busReq=0; o_error is as set; o_busy=1. -> IDLE.
  - o_error clears on the next accepted start.
  - o_result/o_nzcv are not updated on the error path.
- Grant loss mid-transfer (DRIVE/SETTLE/READ) is not supported; the arbiter must hold the grant while o_busReq=1.
- Latency for a valid op with immediate grant: start->o_done = 4 + SETTLE_CYCLES cycles (IDLE, REQ, DRIVE, READ, then DONE).

Decomposition:
- Op codes (ALU_NOP, ALU_SUM_2, ALU_SUB_2) come from the shared alu.vh; the block adds no local op encodings.
- State encodings and the NZCV bit-index constants (N=3, Z=2, C=1, V=0) go into alu.vh alongside the op codes.
- One natural sub-module: alu_bus_driver, a pure tri-state driver for io_bus[15:0] with an enable and 16-bit value, reusable by other bus masters. The FSM stays in the top module.

Test Plan:
- Bench: ALU2 plus an arbiter model.
- Add: i_op=SUM_2, A=0x05, B=0x03, grant immediate -> o_done at cycle 4, o_result=0x08, o_nzcv[3:1]=000, o_error=0.
- Add with carry/zero: SUM_2, A=0xFF, B=0x01 -> o_result=0x00, N=0, Z=1, C=1. o_nzcv[0] must equal i_aluNzcv[0] as sampled during READ.
- Subtract with borrow: SUB_2, A=0x03, B=0x05 -> o_result=0xFE, N=1, Z=0, C=1. Repeat with SETTLE_CYCLES=3 -> o_done at cycle 7 and same result.
- Bad op / timeout:
  - i_op=ALU_NOP -> o_done+o_error one cycle after start; o_busReq never asserted; o_result unchanged.
  - Grant held low, GRANT_TIMEOUT=4 -> o_error after 4 REQ cycles.
- Protocol: i_start pulsed during READ is ignored. i_reset during SETTLE -> next cycle io_bus all Z, o_busReq=0, no o_done. A following op then completes normally. No cycle ever has both this block and the ALU driving bus[7:0] (check for X).
